fb_write_arbiter: RTL
=====================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: framebuffer address width.
REQ-002 Parameter DATA_WIDTH, default 24: pixel width.
REQ-003 Parameter FB_DEPTH, default 76800: number of valid pixel addresses (0..FB_DEPTH-1), SHALL be ≤ 2**ADDR_WIDTH.
REQ-004 clk  in  1  single clock for all logic; the framebuffer write port is driven from this domain.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 a_valid/a_ready  in/out  1  requester A write handshake.
REQ-007 a_addr/a_data  in  ADDR_WIDTH/DATA_WIDTH  requester A pixel address and data.
REQ-008 b_valid/b_ready, b_addr, b_data: same as REQ-006/007 for requester B.
REQ-009 clr_start  in  1  one-cycle pulse: fill the whole framebuffer.
REQ-010 clr_color  in  DATA_WIDTH  fill value, sampled with clr_start.
REQ-011 clr_busy  out  1  fill in progress.
REQ-012 clr_done  out  1  one-cycle pulse on the final fill write.
REQ-013 oob_drop  out  1  one-cycle pulse: an accepted write was discarded as out of range.
REQ-014 fb_en_wr, fb_wrea  out  1  framebuffer write enable and write strobe.
REQ-015 fb_addr_wr, fb_din  out  ADDR_WIDTH/DATA_WIDTH  framebuffer write address and data.

Function
REQ-016 The block SHALL use a two-state FSM: ARB and CLEAR.
REQ-017 Transfer: valid&&ready in the same cycle; ready is combinational from both valids, clr_start and state only.
REQ-018 In ARB, with clr_start low, exactly one requester SHALL be granted when any valid is high.
REQ-019 A lone valid requester SHALL be granted.
REQ-020 When both valids are high, grant SHALL go to the requester not granted most recently (round-robin).
REQ-021 Pointer updates on every transfer, including dropped ones.
REQ-022 After reset, A wins the first contention.
REQ-023 Latency: a transfer in cycle N SHALL drive fb_en_wr=fb_wrea=1 with its addr/data in cycle N+1.
REQ-024 All fb_* outputs SHALL be registered.
REQ-025 Back-to-back transfers SHALL give one write per cycle.
REQ-026 Out of range: transfer with addr ≥ FB_DEPTH is accepted, with fb_en_wr=fb_wrea=0 and oob_drop=1 in cycle N+1.
REQ-027 In cycles with no write, fb_en_wr=fb_wrea=0; fb_addr_wr/fb_din hold their previous values.
REQ-028 Clear priority: clr_start high in ARB during cycle T SHALL force both readys low in T and latch clr_color.
REQ-029 After REQ-028, the FSM enters CLEAR.
REQ-030 Clear sequence: fill write to address k SHALL appear in cycle T+1+k, k=0..FB_DEPTH-1, with fb_din=latched color and ascending addresses without gaps.
REQ-031 a_ready=b_ready=0 in cycles T..T+FB_DEPTH-1.
REQ-032 The FSM returns to ARB so that a transfer is possible in cycle T+FB_DEPTH; its write appears in T+FB_DEPTH+1.
REQ-033 clr_busy SHALL be 1 in cycles T+1..T+FB_DEPTH.
REQ-034 clr_done SHALL be 1 only in cycle T+FB_DEPTH.
REQ-035 clr_start while already in CLEAR SHALL be ignored; clr_color changes during CLEAR have no effect.
REQ-036 Pending valids SHALL be held by the requesters (not lost) during CLEAR.
REQ-037 The fill counter is ADDR_WIDTH bits, compares against FB_DEPTH-1, and never wraps past it.

Reset
REQ-038 rst_n low SHALL immediately force: state ARB; fb_en_wr, fb_wrea, clr_busy, clr_done and oob_drop 0; fb_addr_wr and fb_din 0; fill counter 0; round-robin pointer "B last".
REQ-039 Reset during CLEAR SHALL abort the fill with no clr_done pulse; no write SHALL issue in the first cycle after rst_n rises.

Verification (FB_DEPTH=16, ADDR_WIDTH=5, DATA_WIDTH=24)
REQ-040 Scenario: A only, addr 3 data 0x112233 in cycle N -> cycle N+1: fb_en_wr=1, fb_addr_wr=3, fb_din=0x112233.
REQ-041 Scenario: A and B held valid for 4 cycles after reset -> grants A,B,A,B; four consecutive writes.
REQ-042 Scenario: B addr 20, data 0xABCDEF -> b_ready=1; next cycle fb_en_wr=0, oob_drop=1.
REQ-043 Scenario: clr_start with color 0x0000FF at T, A valid throughout -> addrs 0..15 in T+1..T+16, clr_done at T+16.
REQ-044 Scenario (continues REQ-043): a_ready low in T..T+15; A write appears in T+17.
REQ-045 Scenario: rst_n low at fill address 7 -> outputs zero immediately, no clr_done; new clr_start restarts from address 0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - two-requester framebuffer write arbiter with full-screen fill
module fb_write_arbiter #(
    parameter int          ADDR_WIDTH = 17,
    parameter int          DATA_WIDTH = 24,
    parameter int unsigned FB_DEPTH   = 76800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    input  logic                  i_clr_start,
    input  logic [DATA_WIDTH-1:0] i_clr_color,
    output logic                  o_clr_busy,
    output logic                  o_clr_done,
    output logic                  o_oob_drop,
    output logic                  o_fb_en_wr,
    output logic                  o_fb_wrea,
    output logic [ADDR_WIDTH-1:0] o_fb_addr_wr,
    output logic [DATA_WIDTH-1:0] o_fb_din
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic                  MULTI     = (FB_DEPTH > 1);

    state_t                  r_state, w_state_nx;
    logic                    r_last_b;
    logic [ADDR_WIDTH-1:0]   r_fill_cnt;
    logic [DATA_WIDTH-1:0]   r_color;
    logic                    r_fb_en, r_busy, r_done, r_oob;
    logic [ADDR_WIDTH-1:0]   r_fb_addr;
    logic [DATA_WIDTH-1:0]   r_fb_din;

    logic                    w_a_ready, w_b_ready, w_start;
    logic                    w_xfer_a, w_xfer_b, w_xfer, w_in_range;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;

    always_comb begin
        w_state_nx = r_state;
        w_a_ready  = 1'b0;
        w_b_ready  = 1'b0;
        w_start    = 1'b0;
        case (r_state)
            ARB: begin
                if (i_clr_start) begin
                    w_start = 1'b1;
                    if (MULTI)
                        w_state_nx = CLEAR;
                end else if (i_a_valid && i_b_valid) begin
                    // r_last_b set means B won last, so A gets this contention
                    w_a_ready = r_last_b;
                    w_b_ready = !r_last_b;
                end else begin
                    w_a_ready = i_a_valid;
                    w_b_ready = i_b_valid;
                end
            end
            CLEAR: begin
                if (r_fill_cnt == LAST_ADDR)
                    w_state_nx = ARB;
            end
            default: w_state_nx = ARB;
        endcase
    end

    assign w_xfer_a   = i_a_valid && w_a_ready;
    assign w_xfer_b   = i_b_valid && w_b_ready;
    assign w_xfer     = w_xfer_a || w_xfer_b;
    assign w_addr     = w_xfer_b ? i_b_addr : i_a_addr;
    assign w_data     = w_xfer_b ? i_b_data : i_a_data;
    assign w_in_range = (32'(w_addr) < FB_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ARB;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b   <= 1'b1;
            r_fill_cnt <= '0;
            r_color    <= '0;
            r_fb_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_oob      <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_din   <= '0;
        end else begin
            r_fb_en <= 1'b0;
            r_done  <= 1'b0;
            r_oob   <= 1'b0;
            r_busy  <= w_start || (r_state == CLEAR);
            if (w_start) begin
                // address 0 is written straight from the start cycle; the counter takes over at 1
                r_color    <= i_clr_color;
                r_fb_en    <= 1'b1;
                r_fb_addr  <= '0;
                r_fb_din   <= i_clr_color;
                r_fill_cnt <= MULTI ? ADDR_WIDTH'(1) : '0;
                r_done     <= !MULTI;
            end else if (r_state == CLEAR) begin
                r_fb_en   <= 1'b1;
                r_fb_addr <= r_fill_cnt;
                r_fb_din  <= r_color;
                if (r_fill_cnt == LAST_ADDR)
                    r_done <= 1'b1;
                else
                    r_fill_cnt <= r_fill_cnt + 1'b1;
            end else if (w_xfer) begin
                r_last_b <= w_xfer_b;
                if (w_in_range) begin
                    r_fb_en   <= 1'b1;
                    r_fb_addr <= w_addr;
                    r_fb_din  <= w_data;
                end else begin
                    r_oob <= 1'b1;
                end
            end
        end
    end

    assign o_a_ready    = w_a_ready;
    assign o_b_ready    = w_b_ready;
    assign o_clr_busy   = r_busy;
    assign o_clr_done   = r_done;
    assign o_oob_drop   = r_oob;
    assign o_fb_en_wr   = r_fb_en;
    assign o_fb_wrea    = r_fb_en;
    assign o_fb_addr_wr = r_fb_addr;
    assign o_fb_din     = r_fb_din;

endmodule
